cnn_layer_sched: RTL and testbench

Layer-level scheduler for the single-output-channel CNN engine (conv → pool → ReLU). It runs one engine pass per output channel of a layer, up to the configured channel count. For each pass it drives the channel index that selects kernel bank and bias, pulses the engine start, waits for the engine finish, then strobes a write of the engine's output map into the channel-indexed output buffer. It sits between the layer-sequencing host and the engine instance.

---
 rtl/cnn_sched_pkg.sv | 22 ++
 rtl/cnn_sched_if.sv | 21 ++
 rtl/cnn_sched_wdt.sv | 40 ++++
 rtl/cnn_layer_sched.sv | 167 ++++++++++++++++
 tb/tb_cnn_layer_sched.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_sched_pkg.sv
// Shared state encoding and default sizing for the CNN layer scheduler.
package cnn_sched_pkg;

    localparam int DEF_OUT_CH     = 8;
    localparam int DEF_CH_WIDTH   = 3;
    localparam int DEF_WDT_CYCLES = 4096;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_LAUNCH = S_LAUNCH,
        ST_WAIT   = S_WAIT,
        ST_WRITE  = S_WRITE,
        ST_DONE   = S_DONE
    } state_e;

endpackage

// File: rtl/cnn_sched_if.sv
// Scheduler <-> engine/output-buffer handshake; master is the scheduler side.
interface cnn_sched_if import cnn_sched_pkg::*; #(
    parameter int CH_WIDTH = DEF_CH_WIDTH
);
    logic                cnn_start;
    logic                cnn_idle;
    logic                cnn_finish;
    logic [CH_WIDTH-1:0] ch_idx;
    logic                ofm_we;
    logic [CH_WIDTH-1:0] ofm_waddr;

    modport master (
        output cnn_start, ch_idx, ofm_we, ofm_waddr,
        input  cnn_idle, cnn_finish
    );

    modport slave (
        input  cnn_start, ch_idx, ofm_we, ofm_waddr,
        output cnn_idle, cnn_finish
    );
endinterface

// File: rtl/cnn_sched_wdt.sv
// Loadable down-counter; timeout_o flags the LIMIT-th enabled cycle after a load.
module cnn_sched_wdt import cnn_sched_pkg::*; #(
    parameter int LIMIT = DEF_WDT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic timeout_o
);
    localparam int             CW       = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  LOAD_VAL = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: reload on entry to the wait, then count down to zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (en_i && (count_q != {CW{1'b0}})) begin
            count_d = count_q - CW'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = en_i && (count_q == {CW{1'b0}});

endmodule

// File: rtl/cnn_layer_sched.sv
// Layer scheduler: one engine pass per output channel, then an output-buffer write.
// Optional engine-finish watchdog enabled with CNN_SCHED_WDT_EN.
module cnn_layer_sched import cnn_sched_pkg::*; #(
    parameter int OUT_CH     = DEF_OUT_CH,
    parameter int CH_WIDTH   = DEF_CH_WIDTH,
    parameter int WDT_CYCLES = DEF_WDT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              layer_start,
    input  logic [CH_WIDTH:0] num_ch,
    input  logic              abort,
    output logic              layer_busy,
    output logic              layer_done,
    output logic              wdt_err,
    cnn_sched_if.master       eng
);
    localparam logic [CH_WIDTH:0] OUT_CH_W = (CH_WIDTH + 1)'(OUT_CH);
    localparam logic [CH_WIDTH:0] ONE_W    = (CH_WIDTH + 1)'(1);

    if ((OUT_CH < 1) || (OUT_CH > (1 << CH_WIDTH)) || (WDT_CYCLES < 1)) begin : g_bad_cfg
        $error("cnn_layer_sched: invalid OUT_CH/CH_WIDTH/WDT_CYCLES");
    end

    state_e              state_q,      state_d;
    logic [CH_WIDTH:0]   num_ch_q,     num_ch_d;
    logic [CH_WIDTH-1:0] ch_idx_q,     ch_idx_d;
    logic [CH_WIDTH-1:0] ofm_waddr_q,  ofm_waddr_d;
    logic                cnn_start_q,  cnn_start_d;
    logic                ofm_we_q,     ofm_we_d;
    logic                layer_done_q, layer_done_d;
    logic                layer_busy_q, layer_busy_d;
    logic                wdt_err_q,    wdt_err_d;
    logic                wdt_timeout_s;
    logic                last_ch_s;

`ifdef CNN_SCHED_WDT_EN
    logic wdt_load_s;
    logic wdt_en_s;

    assign wdt_load_s = (state_q == ST_LAUNCH) && eng.cnn_idle && !abort;
    assign wdt_en_s   = (state_q == ST_WAIT);

    cnn_sched_wdt #(
        .LIMIT (WDT_CYCLES)
    ) u_wdt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (wdt_load_s),
        .en_i      (wdt_en_s),
        .timeout_o (wdt_timeout_s)
    );
`else
    assign wdt_timeout_s = 1'b0;
`endif

    assign last_ch_s = (({1'b0, ch_idx_q} + ONE_W) == num_ch_q);

    // Next-state and next-output logic; abort beats every other event.
    always_comb begin
        state_d      = state_q;
        num_ch_d     = num_ch_q;
        ch_idx_d     = ch_idx_q;
        cnn_start_d  = 1'b0;
        ofm_we_d     = 1'b0;
        layer_done_d = 1'b0;
        wdt_err_d    = wdt_err_q;
        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            ch_idx_d = {CH_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (layer_start) begin
                        ch_idx_d  = {CH_WIDTH{1'b0}};
                        wdt_err_d = 1'b0;
                        if (num_ch == {(CH_WIDTH + 1){1'b0}}) begin
                            num_ch_d = num_ch;
                            state_d  = ST_DONE;
                        end else if (num_ch > OUT_CH_W) begin
                            num_ch_d = OUT_CH_W;
                            state_d  = ST_LAUNCH;
                        end else begin
                            num_ch_d = num_ch;
                            state_d  = ST_LAUNCH;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    if (eng.cnn_idle) begin
                        cnn_start_d = 1'b1;
                        state_d     = ST_WAIT;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
                ST_WAIT: begin
                    if (eng.cnn_finish) begin
                        ofm_we_d = 1'b1;
                        state_d  = ST_WRITE;
                    end else if (wdt_timeout_s) begin
                        wdt_err_d = 1'b1;
                        ch_idx_d  = {CH_WIDTH{1'b0}};
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WRITE: begin
                    if (last_ch_s) begin
                        state_d = ST_DONE;
                    end else begin
                        ch_idx_d = ch_idx_q + CH_WIDTH'(1'b1);
                        state_d  = ST_LAUNCH;
                    end
                end
                ST_DONE: begin
                    layer_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: begin
                    ch_idx_d = {CH_WIDTH{1'b0}};
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    assign layer_busy_d = (state_d != ST_IDLE);
    assign ofm_waddr_d  = ch_idx_q;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            num_ch_q     <= {(CH_WIDTH + 1){1'b0}};
            ch_idx_q     <= {CH_WIDTH{1'b0}};
            ofm_waddr_q  <= {CH_WIDTH{1'b0}};
            cnn_start_q  <= 1'b0;
            ofm_we_q     <= 1'b0;
            layer_done_q <= 1'b0;
            layer_busy_q <= 1'b0;
            wdt_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_ch_q     <= num_ch_d;
            ch_idx_q     <= ch_idx_d;
            ofm_waddr_q  <= ofm_waddr_d;
            cnn_start_q  <= cnn_start_d;
            ofm_we_q     <= ofm_we_d;
            layer_done_q <= layer_done_d;
            layer_busy_q <= layer_busy_d;
            wdt_err_q    <= wdt_err_d;
        end
    end

    assign layer_busy    = layer_busy_q;
    assign layer_done    = layer_done_q;
    assign wdt_err       = wdt_err_q;
    assign eng.cnn_start = cnn_start_q;
    assign eng.ch_idx    = ch_idx_q;
    assign eng.ofm_we    = ofm_we_q;
    assign eng.ofm_waddr = ofm_waddr_q;

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Directed self-checking bench for cnn_layer_sched with a fixed-latency engine model.
module tb_cnn_layer_sched;
    import cnn_sched_pkg::*;

    localparam int ENG_LAT = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       layer_start = 1'b0;
    logic [3:0] num_ch = 4'd0;
    logic       abort = 1'b0;
    logic       layer_busy;
    logic       layer_done;
    logic       wdt_err;

    logic eng_finish = 1'b0;
    logic tb_finish  = 1'b0;
    logic hold_busy  = 1'b0;
    logic eng_auto   = 1'b1;
    int   eng_cnt    = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_start_seen = 0;
    int n_we_seen    = 0;
    int n_done_seen  = 0;
    int waddr_log [0:63];

    cnn_sched_if #(.CH_WIDTH(3)) bus ();

    assign bus.cnn_finish = eng_finish | tb_finish;
    assign bus.cnn_idle   = (eng_cnt == 0) && !hold_busy;

    cnn_layer_sched #(
        .OUT_CH     (8),
        .CH_WIDTH   (3),
        .WDT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .layer_start (layer_start),
        .num_ch      (num_ch),
        .abort       (abort),
        .layer_busy  (layer_busy),
        .layer_done  (layer_done),
        .wdt_err     (wdt_err),
        .eng         (bus)
    );

    always #5 clk = ~clk;

    // Engine model: finishes ENG_LAT cycles after it sees a start pulse.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            eng_finish = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) eng_finish = 1'b1;
            end else if (bus.cnn_start && eng_auto) begin
                eng_cnt = ENG_LAT;
            end
        end
    end

    // Event log sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.cnn_start) n_start_seen <= n_start_seen + 1;
        if (layer_done) n_done_seen <= n_done_seen + 1;
        if (bus.ofm_we) begin
            waddr_log[n_we_seen % 64] <= int'(bus.ofm_waddr);
            n_we_seen <= n_we_seen + 1;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_layer(input logic [3:0] n);
        layer_start = 1'b1;
        num_ch = n;
        tick();
        layer_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (!layer_done && cycles < budget) begin
            tick();
            cycles++;
        end
        check_eq({tag, "_done_seen"}, int'(layer_done), 1);
    endtask

    initial begin
        int t0, cyc_n, s0, w0, d0;
        #100000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int cyc_n, s0, w0, d0;

        // Reset state.
        tick();
        tick();
        check_eq("rst_busy", int'(layer_busy), 0);
        check_eq("rst_done", int'(layer_done), 0);
        check_eq("rst_start", int'(bus.cnn_start), 0);
        check_eq("rst_we", int'(bus.ofm_we), 0);
        check_eq("rst_ch_idx", int'(bus.ch_idx), 0);
        check_eq("rst_waddr", int'(bus.ofm_waddr), 0);
        check_eq("rst_wdt", int'(wdt_err), 0);
        rst_n = 1'b1;
        tick();

        // Three channels, 13-cycle pass each.
        s0 = n_start_seen; w0 = n_we_seen; d0 = n_done_seen;
        start_layer(4'd3);
        check_eq("t1_busy", int'(layer_busy), 1);
        check_eq("t1_start_e0", int'(bus.cnn_start), 0);
        tick();
        check_eq("t1_start_e1", int'(bus.cnn_start), 1);
        check_eq("t1_ch0", int'(bus.ch_idx), 0);
        tick();
        check_eq("t1_start_pulse", int'(bus.cnn_start), 0);
        wait_done("t1", 200, cyc_n);
        check_eq("t1_latency", cyc_n + 2, 40);
        check_eq("t1_busy_after", int'(layer_busy), 0);
        tick();
        check_eq("t1_done_pulse", int'(layer_done), 0);
        check_eq("t1_n_start", n_start_seen - s0, 3);
        check_eq("t1_n_we", n_we_seen - w0, 3);
        check_eq("t1_waddr0", waddr_log[w0], 0);
        check_eq("t1_waddr1", waddr_log[w0 + 1], 1);
        check_eq("t1_waddr2", waddr_log[w0 + 2], 2);
        check_eq("t1_n_done", n_done_seen - d0, 1);
        check_eq("t1_wdt", int'(wdt_err), 0);

        // Zero channels.
        s0 = n_start_seen; w0 = n_we_seen;
        start_layer(4'd0);
        check_eq("t2_busy", int'(layer_busy), 1);
        check_eq("t2_done_e0", int'(layer_done), 0);
        tick();
        check_eq("t2_done_e1", int'(layer_done), 1);
        check_eq("t2_busy_e1", int'(layer_busy), 0);
        tick();
        check_eq("t2_done_e2", int'(layer_done), 0);
        check_eq("t2_n_start", n_start_seen - s0, 0);
        check_eq("t2_n_we", n_we_seen - w0, 0);

        // Engine busy for 5 edges in LAUNCH.
        s0 = n_start_seen; w0 = n_we_seen;
        hold_busy = 1'b1;
        start_layer(4'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t3_no_start", int'(bus.cnn_start), 0);
            check_eq("t3_ch_hold", int'(bus.ch_idx), 0);
        end
        hold_busy = 1'b0;
        tick();
        check_eq("t3_start_on_idle", int'(bus.cnn_start), 1);
        wait_done("t3", 100, cyc_n);
        check_eq("t3_n_start", n_start_seen - s0, 1);
        check_eq("t3_waddr", waddr_log[w0], 0);
        tick();

        // Abort coinciding with the channel-1 finish.
        eng_auto = 1'b0;
        w0 = n_we_seen; d0 = n_done_seen;
        start_layer(4'd3);
        tick();
        tick();
        tick();
        tb_finish = 1'b1;
        tick();
        tb_finish = 1'b0;
        check_eq("t4_we_ch0", int'(bus.ofm_we), 1);
        check_eq("t4_waddr_ch0", int'(bus.ofm_waddr), 0);
        tick();
        check_eq("t4_ch1", int'(bus.ch_idx), 1);
        tick();
        check_eq("t4_start_ch1", int'(bus.cnn_start), 1);
        tick();
        tb_finish = 1'b1;
        abort = 1'b1;
        tick();
        tb_finish = 1'b0;
        abort = 1'b0;
        check_eq("t4_abort_busy", int'(layer_busy), 0);
        check_eq("t4_abort_we", int'(bus.ofm_we), 0);
        check_eq("t4_abort_ch", int'(bus.ch_idx), 0);
        tick();
        check_eq("t4_abort_done", int'(layer_done), 0);
        check_eq("t4_n_we", n_we_seen - w0, 1);
        check_eq("t4_n_done", n_done_seen - d0, 0);
        eng_auto = 1'b1;
        w0 = n_we_seen;
        start_layer(4'd1);
        tick();
        check_eq("t4_restart_start", int'(bus.cnn_start), 1);
        check_eq("t4_restart_ch", int'(bus.ch_idx), 0);
        wait_done("t4r", 100, cyc_n);
        check_eq("t4_restart_waddr", waddr_log[w0], 0);
        tick();

        // Spurious finishes and a layer_start while busy.
        s0 = n_start_seen; w0 = n_we_seen; d0 = n_done_seen;
        tb_finish = 1'b1;
        tick();
        tb_finish = 1'b0;
        check_eq("t5_idle_we", int'(bus.ofm_we), 0);
        check_eq("t5_idle_busy", int'(layer_busy), 0);
        start_layer(4'd2);
        tb_finish = 1'b1;
        tick();
        tb_finish = 1'b0;
        tick();
        check_eq("t5_launch_we", int'(bus.ofm_we), 0);
        tick();
        layer_start = 1'b1;
        num_ch = 4'd5;
        tick();
        layer_start = 1'b0;
        wait_done("t5", 100, cyc_n);
        check_eq("t5_latency", cyc_n + 4, 27);
        check_eq("t5_n_start", n_start_seen - s0, 2);
        check_eq("t5_n_we", n_we_seen - w0, 2);
        check_eq("t5_waddr0", waddr_log[w0], 0);
        check_eq("t5_waddr1", waddr_log[w0 + 1], 1);
        tick();
        check_eq("t5_n_done", n_done_seen - d0, 1);

        // Channel count above OUT_CH saturates to 8.
        s0 = n_start_seen; w0 = n_we_seen;
        start_layer(4'd12);
        wait_done("t6", 300, cyc_n);
        check_eq("t6_latency", cyc_n, 105);
        tick();
        check_eq("t6_n_start", n_start_seen - s0, 8);
        check_eq("t6_n_we", n_we_seen - w0, 8);
        check_eq("t6_waddr_last", waddr_log[w0 + 7], 7);

`ifdef CNN_SCHED_WDT_EN
        // Engine never finishes: watchdog trips after 16 WAIT cycles.
        eng_auto = 1'b0;
        d0 = n_done_seen;
        start_layer(4'd1);
        for (int i = 0; i < 16; i++) tick();
        check_eq("t7_wdt_pre", int'(wdt_err), 0);
        check_eq("t7_busy_pre", int'(layer_busy), 1);
        tick();
        check_eq("t7_wdt_set", int'(wdt_err), 1);
        check_eq("t7_busy_post", int'(layer_busy), 0);
        tick();
        check_eq("t7_n_done", n_done_seen - d0, 0);
        check_eq("t7_wdt_sticky", int'(wdt_err), 1);
        eng_auto = 1'b1;
        start_layer(4'd1);
        check_eq("t7_wdt_clear", int'(wdt_err), 0);
        wait_done("t7r", 100, cyc_n);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
